conv_seq: RTL and testbench

CONV_SEQ -- requirements
Module: conv_seq

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_seq_if.sv | 49 ++++
 rtl/conv_mac.sv | 50 +++++
 rtl/conv_seq.sv | 117 +++++++++++
 tb/tb_conv_seq.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and constants for the 3x3 sequential
//                convolution MAC (state encoding, tap-select codes,
//                default data/accumulator widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Default widths: 8-bit pixels/weights, 21-bit accumulator holds the
    // full range of nine unsigned-by-signed 8-bit products.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 21;

    // Tap-select codes driven to the external 9:1 window mux.
    // SEL_IDLE makes the mux output zero; SEL_LAST is the final tap.
    localparam logic [3:0] SEL_IDLE = 4'hF;
    localparam logic [3:0] SEL_LAST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_if
//  Description : Handshake/data bundle between the convolution sequencer
//                and its environment (start, tap select, mux data, result
//                valid/ready handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_seq_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic                     start_i;
    logic                     busy_o;
    logic [3:0]               sel_o;
    logic [DATA_W-1:0]        pixel_i;
    logic signed [DATA_W-1:0] weight_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    logic signed [ACC_W-1:0]  res_o;

    // Environment side: issues start, supplies mux data, consumes result.
    modport master (
        output start_i,
        input  busy_o,
        input  sel_o,
        output pixel_i,
        output weight_i,
        input  res_valid_o,
        output res_ready_i,
        input  res_o
    );

    // Sequencer side.
    modport slave (
        input  start_i,
        output busy_o,
        output sel_o,
        input  pixel_i,
        input  weight_i,
        output res_valid_o,
        input  res_ready_i,
        output res_o
    );

endinterface : conv_seq_if
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mac
//  Description : Signed multiply-accumulate. Pixel is unsigned and is
//                zero-extended before multiplying by the signed weight.
//                Accumulator clears on clr, advances on en, and exposes the
//                next-value sum so the caller can capture the final total
//                in the same cycle the last product is added.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 21
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     clr_i,
    input  wire logic                     en_i,
    input  wire logic [DATA_W-1:0]        pixel_i,
    input  wire logic signed [DATA_W-1:0] weight_i,
    output logic signed [ACC_W-1:0]       acc_next_o
);

    // Product width: (DATA_W+1)-bit signed pixel times DATA_W-bit weight.
    localparam int PW = 2 * DATA_W + 1;

    logic signed [PW-1:0]    w_pix_x;
    logic signed [PW-1:0]    w_wt_x;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] r_acc;

    // Extend both operands to the product width so the multiply is exact.
    assign w_pix_x    = {{(DATA_W+1){1'b0}}, pixel_i};
    assign w_wt_x     = {{(DATA_W+1){weight_i[DATA_W-1]}}, weight_i};
    assign w_prod     = w_pix_x * w_wt_x;
    assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign acc_next_o = r_acc + w_prod_ext;

    // Accumulator register: reset/clear to zero, otherwise add when enabled.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_acc <= '0;
        end else if (en_i) begin
            r_acc <= acc_next_o;
        end
    end

endmodule : conv_mac
`default_nettype wire

// File: rtl/conv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq
//  Description : Sequential 3x3 convolution window MAC. On start, steps the
//                external window mux through taps 0..8 (one per cycle),
//                accumulates pixel*weight, then presents the result with a
//                valid/ready handshake until consumed.
//                Optional macro CONV_SEQ_RELU_EN clamps negative results to
//                zero when the result is captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_seq
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    conv_seq_if.slave   bus
);

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [3:0]              r_sel;
    logic                    r_busy;
    logic                    r_valid;
    logic signed [ACC_W-1:0] r_res;

    logic                    w_clr;
    logic                    w_en;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_res_next;

    // Clear on the accepted start so the pass begins from zero; add only in RUN.
    assign w_clr = (r_state == ST_IDLE) && bus.start_i;
    assign w_en  = (r_state == ST_RUN);

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_clr),
        .en_i       (w_en),
        .pixel_i    (bus.pixel_i),
        .weight_i   (bus.weight_i),
        .acc_next_o (w_acc_next)
    );

`ifdef CONV_SEQ_RELU_EN
    // ReLU: negative totals become zero at capture time.
    assign w_res_next = w_acc_next[ACC_W-1] ? '0 : w_acc_next;
`else
    assign w_res_next = w_acc_next;
`endif

    // Sequencer FSM with registered outputs; captures the final sum on the
    // last tap so the result is ready the cycle DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_sel   <= SEL_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state <= ST_RUN;
                        r_cnt   <= 4'd0;
                        r_sel   <= 4'd0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == SEL_LAST) begin
                        r_state <= ST_DONE;
                        r_cnt   <= 4'd0;
                        r_sel   <= SEL_IDLE;
                        r_valid <= 1'b1;
                        r_res   <= w_res_next;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        r_sel <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    // start_i is deliberately ignored here; a new pass needs
                    // start asserted again once back in IDLE.
                    if (bus.res_ready_i) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_sel   <= SEL_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.sel_o       = r_sel;
    assign bus.res_valid_o = r_valid;
    assign bus.res_o       = r_res;

endmodule : conv_seq
`default_nettype wire

// File: tb/tb_conv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_seq
//  Description : Directed self-checking bench for conv_seq. A 16-entry
//                table per tap models the external window mux; each test
//                loads the table and compares against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_seq;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conv_seq_if #(.DATA_W(8), .ACC_W(21)) bus ();

    conv_seq #(.DATA_W(8), .ACC_W(21)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Window mux model: entries 9..15 are zero, so SEL_IDLE yields zero.
    logic [7:0]        pix [0:15];
    logic signed [7:0] wt  [0:15];

    assign bus.pixel_i  = pix[bus.sel_o];
    assign bus.weight_i = wt[bus.sel_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pixel[k] = p0 + pstep*k, weight[k] = w for taps 0..8.
    task automatic load(input int p0, input int pstep, input int w);
        for (int i = 0; i < 16; i++) begin
            if (i < 9) begin
                pix[i] = 8'(p0 + pstep * i);
                wt[i]  = 8'(w);
            end else begin
                pix[i] = 8'd0;
                wt[i]  = 8'sd0;
            end
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for res_valid_o.
    // n counts edges from the start-sampling edge to valid.
    task automatic run_to_done(output int n);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 1;
        while (bus.res_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.res_ready_i = 1'b0;
        load(0, 0, 0);
        tick(); tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
            $display("FAIL reset_flags: busy=%b valid=%b, required 0 0", bus.busy_o, bus.res_valid_o);
            errors++;
        end
        checks++;
        if (bus.sel_o !== 4'hF) begin
            $display("FAIL reset_sel: got %h, required F", bus.sel_o);
            errors++;
        end
        checks++;
        if (bus.res_o !== 21'sd0) begin
            $display("FAIL reset_res: got %0d, required 0", $signed(bus.res_o));
            errors++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ones();
        int bad_sel;
        int bad_valid;
        bad_sel = 0;
        bad_valid = 0;
        load(1, 0, 1);
        bus.res_ready_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (bus.sel_o !== 4'(k)) bad_sel++;
            if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) bad_valid++;
            tick();
        end
        checks++;
        if (bad_sel != 0) begin
            $display("FAIL ones_sel_steps: %0d wrong sel cycles, required 0", bad_sel);
            errors++;
        end
        checks++;
        if (bad_valid != 0) begin
            $display("FAIL ones_run_flags: %0d wrong busy/valid cycles, required 0", bad_valid);
            errors++;
        end
        checks++;
        if (bus.res_valid_o !== 1'b1 || bus.sel_o !== 4'hF) begin
            $display("FAIL ones_latency: valid=%b sel=%h at start+10, required 1 F", bus.res_valid_o, bus.sel_o);
            errors++;
        end
        checks++;
        if (bus.res_o !== 21'sd9) begin
            $display("FAIL ones_result: got %0d, required 9", $signed(bus.res_o));
            errors++;
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.sel_o !== 4'hF) begin
            $display("FAIL ones_return_idle: busy=%b valid=%b sel=%h, required 0 0 F",
                     bus.busy_o, bus.res_valid_o, bus.sel_o);
            errors++;
        end
    endtask

    task automatic test_negative();
        int n;
        logic signed [20:0] exp_res;
`ifdef CONV_SEQ_RELU_EN
        exp_res = 21'sd0;
`else
        exp_res = -21'sd293760;
`endif
        load(255, 0, -128);
        bus.res_ready_i = 1'b1;
        run_to_done(n);
        checks++;
        if (n != 10) begin
            $display("FAIL neg_latency: got %0d, required 10", n);
            errors++;
        end
        checks++;
        if (bus.res_o !== exp_res) begin
            $display("FAIL neg_result: got %0d, required %0d", $signed(bus.res_o), exp_res);
            errors++;
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bad = 0;
        load(1, 1, 2);
        bus.res_ready_i = 1'b0;
        run_to_done(n);
        for (int k = 0; k < 5; k++) begin
            if (bus.res_o !== 21'sd90 || bus.busy_o !== 1'b1 || bus.res_valid_o !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d cycles not holding res=90 busy=1 valid=1 (last res %0d), required 0",
                     bad, $signed(bus.res_o));
            errors++;
        end
        checks++;
        if (bus.res_o !== 21'sd90 || bus.res_valid_o !== 1'b1) begin
            $display("FAIL bp_still_done: res=%0d valid=%b, required 90 1", $signed(bus.res_o), bus.res_valid_o);
            errors++;
        end
        bus.res_ready_i = 1'b1;
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
            $display("FAIL bp_release: busy=%b valid=%b, required 0 0", bus.busy_o, bus.res_valid_o);
            errors++;
        end
    endtask

    task automatic test_start_ignored();
        int n;
        int busy_cycles;
        busy_cycles = 0;
        load(1, 0, 1);
        bus.res_ready_i = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick(); tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checks++;
        if (bus.sel_o !== 4'd3) begin
            $display("FAIL ign_run_sel: got %h, required 3", bus.sel_o);
            errors++;
        end
        n = 4;
        while (bus.res_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 10 || bus.res_o !== 21'sd9) begin
            $display("FAIL ign_result: latency %0d res %0d, required 10 9", n, $signed(bus.res_o));
            errors++;
        end
        bus.start_i = 1'b1;
        bus.res_ready_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.res_ready_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 0) begin
            $display("FAIL ign_no_second_pass: %0d busy cycles, required 0", busy_cycles);
            errors++;
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        load(5, 1, 3);
        bus.res_ready_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 0;
        while (bus.sel_o !== 4'd4 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.sel_o !== 4'd4) begin
            $display("FAIL rstmid_reach_tap4: sel=%h, required 4", bus.sel_o);
            errors++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.sel_o !== 4'hF || bus.res_valid_o !== 1'b0 || bus.res_o !== 21'sd0) begin
            $display("FAIL rstmid_idle: busy=%b sel=%h valid=%b res=%0d, required 0 F 0 0",
                     bus.busy_o, bus.sel_o, bus.res_valid_o, $signed(bus.res_o));
            errors++;
        end
        tick();
        load(7, 0, 0);
        run_to_done(n);
        checks++;
        if (n != 10 || bus.res_o !== 21'sd0) begin
            $display("FAIL rstmid_zero_pass: latency %0d res %0d, required 10 0", n, $signed(bus.res_o));
            errors++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        load(1, 1, 1);
        bus.res_ready_i = 1'b1;
        run_to_done(n);
        checks++;
        if (bus.res_o !== 21'sd45) begin
            $display("FAIL b2b_first: got %0d, required 45", $signed(bus.res_o));
            errors++;
        end
        tick();
        load(1, 1, 3);
        run_to_done(n);
        checks++;
        if (n != 10 || bus.res_o !== 21'sd135) begin
            $display("FAIL b2b_second: latency %0d res %0d, required 10 135", n, $signed(bus.res_o));
            errors++;
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b0) begin
            $display("FAIL b2b_idle: busy=%b, required 0", bus.busy_o);
            errors++;
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.res_ready_i = 1'b0;
        rst = 1'b1;
        test_reset();
        test_ones();
        test_negative();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_conv_seq
`default_nettype wire
